// File: rtl/vx_ti_stamp_dispatch_pkg.sv
// vx_ti_stamp_dispatch_pkg: TI stamp/CSR record types, dispatch FSM states and pos_mask packing.
`ifndef VX_TI_DIM_BITS
`define VX_TI_DIM_BITS 12
`endif
`ifndef VX_TI_PID_BITS
`define VX_TI_PID_BITS 8
`endif

package vx_ti_stamp_dispatch_pkg;

    localparam int TI_DIM_BITS = `VX_TI_DIM_BITS;
    localparam int TI_PID_BITS = `VX_TI_PID_BITS;

    typedef struct packed {
        logic [TI_DIM_BITS-2:0]  pos_x;
        logic [TI_DIM_BITS-2:0]  pos_y;
        logic [3:0]              mask;
        logic [2:0][3:0][31:0]   bcoords;
        logic [TI_PID_BITS-1:0]  pid;
    } stamp_t;

    typedef struct packed {
        logic [2:0][3:0][31:0] bcoords;
        logic [31:0]           pos_mask;
    } csrs_t;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    function automatic logic [31:0] pack_pos_mask(input logic [TI_DIM_BITS-2:0] x,
                                                  input logic [TI_DIM_BITS-2:0] y,
                                                  input logic [3:0] m);
        return 32'({y, x, m});
    endfunction

endpackage

// File: rtl/vx_ti_stamp_dispatch_fifo.sv
// vx_ti_stamp_fifo: power-of-2 ring buffer with occupancy count and full/empty flags.
module vx_ti_stamp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

endmodule

// File: rtl/vx_ti_stamp_dispatch.sv
// vx_ti_stamp_dispatch: buffers TI stamps and packs one quad per active lane into warp CSR responses.
// Optional perf counters are enabled with VX_TI_DISPATCH_PERF_EN.
module vx_ti_stamp_dispatch
    import vx_ti_stamp_dispatch_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int DIM_BITS   = TI_DIM_BITS,
    parameter int PID_BITS   = TI_PID_BITS,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stamp_valid,
    output logic                           stamp_ready,
    input  stamp_t                         stamp_data,
    input  logic                           stamp_done,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [TAG_WIDTH-1:0]           req_tag,
    input  logic [NUM_LANES-1:0]           req_tmask,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    output logic [NUM_LANES-1:0]           rsp_mask,
    output csrs_t [NUM_LANES-1:0]          rsp_csrs,
    output logic                           rsp_done
`ifdef VX_TI_DISPATCH_PERF_EN
    ,
    output logic [31:0]                    perf_stamps,
    output logic [31:0]                    perf_stalls
`endif
);
    localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;

    // pid is dropped before buffering, so the FIFO only stores what reaches the CSRs
    typedef struct packed {
        logic [DIM_BITS-2:0]   pos_x;
        logic [DIM_BITS-2:0]   pos_y;
        logic [3:0]            mask;
        logic [2:0][3:0][31:0] bcoords;
    } entry_t;

    state_t                 state, state_next;
    logic [LW-1:0]          lane_idx;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [NUM_LANES-1:0]   tmask_r, mask_r;
    csrs_t [NUM_LANES-1:0]  csrs_r;
    logic                   done_r;
    entry_t                 entry_in, entry_out;
    csrs_t                  pop_csrs;
    logic                   push, pop, full, empty, req_fire, active, stall, drain, last;
    logic [PID_BITS-1:0]    unused_pid;

    assign unused_pid = stamp_data.pid;
    assign entry_in   = {stamp_data.pos_x, stamp_data.pos_y, stamp_data.mask, stamp_data.bcoords};
    assign pop_csrs   = '{bcoords: entry_out.bcoords,
                          pos_mask: pack_pos_mask(entry_out.pos_x, entry_out.pos_y, entry_out.mask)};

    assign stamp_ready = reset && !full;
    assign push        = stamp_valid && stamp_ready;
    assign req_ready   = reset && state == IDLE;
    assign req_fire    = req_valid && req_ready;
    assign active      = state == FILL && tmask_r[lane_idx];
    assign pop         = active && !empty;
    assign stall       = active && empty && !stamp_done;
    assign drain       = active && empty && stamp_done;
    assign last        = lane_idx == LW'(NUM_LANES-1);

    vx_ti_stamp_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (entry_in),
        .dout  (entry_out),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        rsp_valid  = state == RESP;
        state_next = (state == IDLE && req_fire) ? FILL :
                     (state == FILL && (drain || (!stall && last))) ? RESP :
                     (state == RESP && rsp_ready) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_idx <= '0;
            tag_r    <= '0;
            tmask_r  <= '0;
            mask_r   <= '0;
            csrs_r   <= '0;
            done_r   <= 1'b0;
        end else begin
            if (req_fire) begin
                tag_r    <= req_tag;
                tmask_r  <= req_tmask;
                mask_r   <= '0;
                csrs_r   <= '0;
                done_r   <= 1'b0;
                lane_idx <= '0;
            end
            if (state == FILL && !stall && !drain) lane_idx <= lane_idx + 1'b1;
            if (pop) begin
                mask_r[lane_idx] <= 1'b1;
                csrs_r[lane_idx] <= pop_csrs;
            end
            if (drain) done_r <= 1'b1;
        end
    end

    assign rsp_tag  = tag_r;
    assign rsp_mask = mask_r;
    assign rsp_csrs = csrs_r;
    assign rsp_done = done_r;

`ifdef VX_TI_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stamps <= '0;
            perf_stalls <= '0;
        end else begin
            perf_stamps <= perf_stamps + 32'(pop);
            perf_stalls <= perf_stalls + 32'(stall);
        end
    end
`endif

endmodule

// File: tb/tb_vx_ti_stamp_dispatch.sv
// tb_vx_ti_stamp_dispatch: directed self-checking bench for vx_ti_stamp_dispatch.
module tb_vx_ti_stamp_dispatch;
    import vx_ti_stamp_dispatch_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 stamp_valid, stamp_ready, stamp_done;
    stamp_t               stamp_data;
    logic                 req_valid, req_ready;
    logic [7:0]           req_tag;
    logic [3:0]           req_tmask;
    logic                 rsp_valid, rsp_ready, rsp_done;
    logic [7:0]           rsp_tag;
    logic [3:0]           rsp_mask;
    csrs_t [3:0]          rsp_csrs;
`ifdef VX_TI_DISPATCH_PERF_EN
    logic [31:0]          perf_stamps, perf_stalls;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vx_ti_stamp_dispatch dut (
        .clk         (clk),
        .reset       (reset),
        .stamp_valid (stamp_valid),
        .stamp_ready (stamp_ready),
        .stamp_data  (stamp_data),
        .stamp_done  (stamp_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tag     (req_tag),
        .req_tmask   (req_tmask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_tag     (rsp_tag),
        .rsp_mask    (rsp_mask),
        .rsp_csrs    (rsp_csrs),
        .rsp_done    (rsp_done)
`ifdef VX_TI_DISPATCH_PERF_EN
        ,
        .perf_stamps (perf_stamps),
        .perf_stalls (perf_stalls)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic stamp_t mk(input int x, input int y, input logic [3:0] m, input logic [31:0] id);
        stamp_t s;
        s = '0;
        s.pos_x = 11'(x);
        s.pos_y = 11'(y);
        s.mask = m;
        s.bcoords[0][0] = id;
        s.bcoords[2][3] = ~id;
        s.pid = 8'hA5;
        return s;
    endfunction

    task automatic push(input stamp_t s);
        stamp_valid = 1'b1;
        stamp_data = s;
        @(negedge clk);
        stamp_valid = 1'b0;
    endtask

    task automatic request(input logic [7:0] tag, input logic [3:0] tm, output int cyc);
        req_valid = 1'b1;
        req_tag = tag;
        req_tmask = tm;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int acc;
        logic [31:0] hold_pm;
        logic [7:0] hold_tag;
        logic [3:0] hold_mask;
        reset = 1'b0;
        stamp_valid = 1'b0;
        stamp_data = '0;
        stamp_done = 1'b0;
        req_valid = 1'b0;
        req_tag = '0;
        req_tmask = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stamp_ready", {31'd0, stamp_ready}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_mask", {28'd0, rsp_mask}, 32'd0);
        chk("rst_rsp_done", {31'd0, rsp_done}, 32'd0);
        chk("rst_rsp_tag", {24'd0, rsp_tag}, 32'd0);
        chk("rst_rsp_csrs", {31'd0, |rsp_csrs}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_stamp_ready", {31'd0, stamp_ready}, 32'd1);
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // full fill, in-order delivery
        for (int i = 1; i <= 4; i++) push(mk(i, i, 4'hF, 32'(i)));
        request(8'h5A, 4'b1111, cyc);
        chk("fill_latency", 32'(cyc), 32'd5);
        chk("fill_tag", {24'd0, rsp_tag}, 32'h5A);
        chk("fill_mask", {28'd0, rsp_mask}, 32'hF);
        chk("fill_pm0", rsp_csrs[0].pos_mask, 32'h0000_801F);
        chk("fill_pm3", rsp_csrs[3].pos_mask, 32'h0002_004F);
        chk("fill_bc2", rsp_csrs[2].bcoords[0][0], 32'd3);
        chk("fill_bc2_hi", rsp_csrs[2].bcoords[2][3], ~32'd3);
        chk("fill_done", {31'd0, rsp_done}, 32'd0);
        release_rsp();
        chk("fill_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
        chk("fill_req_ready", {31'd0, req_ready}, 32'd1);

        // sparse mask
        for (int i = 0; i < 3; i++) push(mk(5 + i, 5 + i, 4'h3, 32'(11 + i)));
        request(8'h21, 4'b1010, cyc);
        chk("sparse_latency", 32'(cyc), 32'd5);
        chk("sparse_mask", {28'd0, rsp_mask}, 32'b1010);
        chk("sparse_bc1", rsp_csrs[1].bcoords[0][0], 32'd11);
        chk("sparse_bc3", rsp_csrs[3].bcoords[0][0], 32'd12);
        chk("sparse_lane0_zero", {31'd0, |rsp_csrs[0]}, 32'd0);
        chk("sparse_lane2_zero", {31'd0, |rsp_csrs[2]}, 32'd0);
        release_rsp();
        request(8'h22, 4'b0001, cyc);
        chk("sparse_left_mask", {28'd0, rsp_mask}, 32'b0001);
        chk("sparse_left_bc0", rsp_csrs[0].bcoords[0][0], 32'd13);
        chk("sparse_left_pm0", rsp_csrs[0].pos_mask, 32'h0003_8073);
        release_rsp();

        // drain with stamp_done
        push(mk(2, 3, 4'h5, 32'd21));
        stamp_done = 1'b1;
        request(8'h33, 4'b1111, cyc);
        chk("drain_latency", 32'(cyc), 32'd3);
        chk("drain_mask", {28'd0, rsp_mask}, 32'b0001);
        chk("drain_done", {31'd0, rsp_done}, 32'd1);
        chk("drain_pm0", rsp_csrs[0].pos_mask, 32'h0001_8025);
        chk("drain_pm1", rsp_csrs[1].pos_mask, 32'd0);
        release_rsp();
        stamp_done = 1'b0;

        // zero tmask
        request(8'h01, 4'b0000, cyc);
        chk("zero_latency", 32'(cyc), 32'd5);
        chk("zero_mask", {28'd0, rsp_mask}, 32'd0);
        chk("zero_done", {31'd0, rsp_done}, 32'd0);
        release_rsp();

        // back-pressure
        acc = 0;
        stamp_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            stamp_data = mk(k, 0, 4'hF, 32'(100 + k));
            #1;
            if (stamp_ready) acc++;
            @(negedge clk);
        end
        stamp_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd16);
        chk("bp_ready_low", {31'd0, stamp_ready}, 32'd0);
        request(8'h44, 4'b1111, cyc);
        hold_pm = rsp_csrs[0].pos_mask;
        hold_tag = rsp_tag;
        hold_mask = rsp_mask;
        chk("bp_ready_back", {31'd0, stamp_ready}, 32'd1);
        chk("bp_bc0", rsp_csrs[0].bcoords[0][0], 32'd100);
        repeat (5) @(negedge clk);
        chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_hold_tag", {24'd0, rsp_tag}, {24'd0, hold_tag});
        chk("bp_hold_mask", {28'd0, rsp_mask}, {28'd0, hold_mask});
        chk("bp_hold_pm0", rsp_csrs[0].pos_mask, hold_pm);
        release_rsp();
        for (int r = 0; r < 3; r++) begin
            request(8'h45, 4'b1111, cyc);
            release_rsp();
        end
        chk("bp_last_bc3", rsp_csrs[3].bcoords[0][0], 32'd115);

        // stall and release
        req_valid = 1'b1;
        req_tag = 8'h55;
        req_tmask = 4'b0001;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_no_rsp", {31'd0, rsp_valid}, 32'd0);
        push(mk(9, 9, 4'h1, 32'd200));
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stall_mask", {28'd0, rsp_mask}, 32'b0001);
        chk("stall_bc0", rsp_csrs[0].bcoords[0][0], 32'd200);
`ifdef VX_TI_DISPATCH_PERF_EN
        chk("perf_stalls_ge10", {31'd0, perf_stalls >= 32'd10}, 32'd1);
        chk("perf_stamps", perf_stamps, 32'd25);
`endif
        release_rsp();

        // reset mid-FILL
        for (int i = 0; i < 3; i++) push(mk(1, 2, 4'h7, 32'(300 + i)));
        req_valid = 1'b1;
        req_tag = 8'h66;
        req_tmask = 4'b1111;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_two_lanes", {28'd0, rsp_mask}, 32'b0011);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_req_ready_in_rst", {31'd0, req_ready}, 32'd0);
        chk("mid_stamp_ready_in_rst", {31'd0, stamp_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_mask_cleared", {28'd0, rsp_mask}, 32'd0);
        stamp_done = 1'b1;
        request(8'h67, 4'b0001, cyc);
        chk("mid_fifo_empty_mask", {28'd0, rsp_mask}, 32'd0);
        chk("mid_fifo_empty_done", {31'd0, rsp_done}, 32'd1);
        release_rsp();
        stamp_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
